// File: rtl/set_tag_ctrl_pkg.sv
// Shared types and constants for the 8-way set tag controller.
// Imported by the interface, the way matcher and the controller top.
package set_tag_ctrl_pkg;

  localparam int WAYS  = 8;
  localparam int WAY_W = 3;

  typedef logic [WAY_W-1:0] way_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_FILL      = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

endpackage

// File: rtl/set_tag_ctrl_if.sv
// Bundles the core request/response, flush, memory refill and LRU signals of one set.
// master = environment (core, memory, LRU tracker); slave = the tag controller.
interface set_tag_ctrl_if #(
  parameter int TAG_W = 8
);
  import set_tag_ctrl_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_hit;
  way_t             resp_way;
  logic             flush;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [TAG_W-1:0] mem_req_tag;
  logic             mem_fill_valid;
  way_t             lru_way;
  logic             lru_touch;
  way_t             lru_touch_way;

  modport master (
    output req_valid, req_tag, flush, mem_req_ready, mem_fill_valid, lru_way,
    input  req_ready, resp_valid, resp_hit, resp_way,
           mem_req_valid, mem_req_tag, lru_touch, lru_touch_way
  );

  modport slave (
    input  req_valid, req_tag, flush, mem_req_ready, mem_fill_valid, lru_way,
    output req_ready, resp_valid, resp_hit, resp_way,
           mem_req_valid, mem_req_tag, lru_touch, lru_touch_way
  );

endinterface

// File: rtl/set_tag_ctrl_way_match.sv
// Combinational tag compare across all ways plus lowest-index free way search.
// The controller guarantees at most one valid way holds any given tag.
module set_tag_ctrl_way_match
  import set_tag_ctrl_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic [WAYS-1:0][TAG_W-1:0] tags_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       hit_o,
  output way_t                       hit_way_o,
  output logic                       any_invalid_o,
  output way_t                       first_invalid_way_o
);

  always_comb begin
    hit_o               = 1'b0;
    hit_way_o           = '0;
    any_invalid_o       = ~&valid_i;
    first_invalid_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_i[w] && (tags_i[w] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = way_t'(w);
      end
    end
    // Scan downwards so the lowest free way is the last (winning) assignment.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) first_invalid_way_o = way_t'(w);
    end
  end

endmodule

// File: rtl/set_tag_ctrl.sv
// Tag/valid store and miss controller for one 8-way cache set.
// Hits touch the LRU tracker; misses pick a victim, refill from memory, then install.
module set_tag_ctrl
  import set_tag_ctrl_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  set_tag_ctrl_if.slave bus
);

  state_e                     state_q, state_d;
  logic [WAYS-1:0]            valid_q, valid_d;
  logic [WAYS-1:0][TAG_W-1:0] tags_q, tags_d;
  logic [TAG_W-1:0]           req_tag_q, req_tag_d;
  way_t                       victim_q, victim_d;
  logic                       resp_hit_q, resp_hit_d;
  way_t                       resp_way_q, resp_way_d;
  way_t                       touch_way_q, touch_way_d;

  logic lru_touch;
  way_t touch_way_now;

  logic match_hit;
  way_t match_way;
  logic any_invalid;
  way_t first_invalid;

  set_tag_ctrl_way_match #(
    .TAG_W (TAG_W)
  ) u_way_match (
    .tags_i              (tags_q),
    .valid_i             (valid_q),
    .tag_i               (req_tag_q),
    .hit_o               (match_hit),
    .hit_way_o           (match_way),
    .any_invalid_o       (any_invalid),
    .first_invalid_way_o (first_invalid)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    valid_d       = valid_q;
    tags_d        = tags_q;
    req_tag_d     = req_tag_q;
    victim_d      = victim_q;
    resp_hit_d    = resp_hit_q;
    resp_way_d    = resp_way_q;
    touch_way_d   = touch_way_q;
    lru_touch     = 1'b0;
    touch_way_now = touch_way_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          valid_d = '0;
        end else if (bus.req_valid) begin
          req_tag_d = bus.req_tag;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (match_hit) begin
          lru_touch     = 1'b1;
          touch_way_now = match_way;
          touch_way_d   = match_way;
          resp_hit_d    = 1'b1;
          resp_way_d    = match_way;
          state_d       = ST_RESP;
        end else begin
          // Free ways are always consumed before the LRU victim is evicted.
          victim_d = any_invalid ? first_invalid : bus.lru_way;
          state_d  = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (bus.mem_req_ready) state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (bus.mem_fill_valid) state_d = ST_FILL;
      end
      ST_FILL: begin
        tags_d[victim_q]  = req_tag_q;
        valid_d[victim_q] = 1'b1;
        lru_touch         = 1'b1;
        touch_way_now     = victim_q;
        touch_way_d       = victim_q;
        resp_hit_d        = 1'b0;
        resp_way_d        = victim_q;
        state_d           = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the tag array is reset too, so lookups after reset never see stale X tags.
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      tags_q      <= '0;
      req_tag_q   <= '0;
      victim_q    <= '0;
      resp_hit_q  <= 1'b0;
      resp_way_q  <= '0;
      touch_way_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q     <= state_d;
      valid_q     <= valid_d;
      tags_q      <= tags_d;
      req_tag_q   <= req_tag_d;
      victim_q    <= victim_d;
      resp_hit_q  <= resp_hit_d;
      resp_way_q  <= resp_way_d;
      touch_way_q <= touch_way_d;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE) && !bus.flush;
  assign bus.resp_valid    = (state_q == ST_RESP);
  assign bus.resp_hit      = resp_hit_q;
  assign bus.resp_way      = resp_way_q;
  assign bus.mem_req_valid = (state_q == ST_MISS_REQ);
  assign bus.mem_req_tag   = req_tag_q;
  assign bus.lru_touch     = lru_touch;
  assign bus.lru_touch_way = touch_way_now;

endmodule
